// File: rtl/alu_ctrl_mc.sv
// Multi-cycle ALU control decoder and datapath with an iterative shift-add multiplier.
// Single-cycle ops complete on the accept edge; MUL holds ready_o low for DATA_W cycles.
module alu_ctrl_mc #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned CNT_W  = 7
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  input  logic [1:0]        ALUOp_i,
  input  logic [3:0]        funct_i,
  input  logic [DATA_W-1:0] src1_i,
  input  logic [DATA_W-1:0] src2_i,
  output logic              ready_o,
  output logic [3:0]        ALUCtrl_o,
  output logic [DATA_W-1:0] result_o,
  output logic              zero_o,
  output logic              done_o,
  output logic              err_o
);

  localparam int unsigned CTRL_W = 4;

  localparam logic [CTRL_W-1:0] CTRL_AND = 4'b0000;
  localparam logic [CTRL_W-1:0] CTRL_OR  = 4'b0001;
  localparam logic [CTRL_W-1:0] CTRL_ADD = 4'b0010;
  localparam logic [CTRL_W-1:0] CTRL_SUB = 4'b0110;
  localparam logic [CTRL_W-1:0] CTRL_SLT = 4'b0111;
  localparam logic [CTRL_W-1:0] CTRL_MUL = 4'b1000;
  localparam logic [CTRL_W-1:0] CTRL_ILL = 4'b1111;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic                ready_q, ready_d;
  logic [CTRL_W-1:0]   ctrl_q, ctrl_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic                zero_q, zero_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   mcand_q, mcand_d;
  logic [DATA_W-1:0]   mplier_q, mplier_d;
  logic [DATA_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic [CTRL_W-1:0]   ctrl_c;
  logic [DATA_W-1:0]   alu_c;
  logic [DATA_W-1:0]   mul_step_c;
  logic                last_iter_c;
  logic                accept_c;

  // {ALUOp, funct} -> ALU control code
  always_comb begin
    ctrl_c = CTRL_ILL;
    case (ALUOp_i)
      2'b10: begin
        case (funct_i)
          4'b0111: ctrl_c = CTRL_AND;
          4'b0110: ctrl_c = CTRL_OR;
          4'b0000: ctrl_c = CTRL_ADD;
          4'b1000: ctrl_c = CTRL_SUB;
          4'b0010: ctrl_c = CTRL_SLT;
          default: ctrl_c = CTRL_ILL;
        endcase
      end
      2'b00: begin
        case (funct_i[2:0])
          3'b011:  ctrl_c = CTRL_ADD;
          3'b000:  ctrl_c = CTRL_ADD;
          3'b010:  ctrl_c = CTRL_SLT;
          default: ctrl_c = CTRL_ILL;
        endcase
      end
      2'b01:   ctrl_c = CTRL_SUB;
      default: ctrl_c = (funct_i[2:0] == 3'b000) ? CTRL_MUL : CTRL_ILL;
    endcase
  end

  // Single-cycle datapath; illegal and MUL codes yield zero here
  always_comb begin
    alu_c = '0;
    case (ctrl_c)
      CTRL_AND: alu_c = src1_i & src2_i;
      CTRL_OR:  alu_c = src1_i | src2_i;
      CTRL_ADD: alu_c = src1_i + src2_i;
      CTRL_SUB: alu_c = src1_i - src2_i;
      CTRL_SLT: alu_c = DATA_W'($signed(src1_i) < $signed(src2_i));
      default:  alu_c = '0;
    endcase
  end

  assign accept_c    = valid_i & ready_q;
  assign mul_step_c  = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign last_iter_c = (cnt_q == CNT_W'(DATA_W - 1));

  // Next-state and registered-output logic
  always_comb begin
    state_d  = state_q;
    ctrl_d   = ctrl_q;
    result_d = result_q;
    zero_d   = zero_q;
    done_d   = 1'b0;
    err_d    = err_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;

    case (state_q)
      IDLE: begin
        if (accept_c) begin
          ctrl_d = ctrl_c;
          if (ctrl_c == CTRL_MUL) begin
            mcand_d  = src1_i;
            mplier_d = src2_i;
            acc_d    = '0;
            cnt_d    = '0;
            state_d  = MUL;
          end else begin
            result_d = alu_c;
            zero_d   = (alu_c == '0);
            err_d    = (ctrl_c == CTRL_ILL);
            done_d   = 1'b1;
          end
        end
      end
      MUL: begin
        acc_d    = mul_step_c;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (last_iter_c) begin
          result_d = mul_step_c;
          zero_d   = (mul_step_c == '0);
          err_d    = 1'b0;
          done_d   = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      ready_q  <= 1'b1;
      ctrl_q   <= '0;
      result_q <= '0;
      zero_q   <= 1'b1;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      ready_q  <= ready_d;
      ctrl_q   <= ctrl_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      done_q   <= done_d;
      err_q    <= err_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end

  assign ready_o   = ready_q;
  assign ALUCtrl_o = ctrl_q;
  assign result_o  = result_q;
  assign zero_o    = zero_q;
  assign done_o    = done_q;
  assign err_o     = err_q;

endmodule

// File: tb/tb_alu_ctrl_mc.sv
// Scoreboard bench for alu_ctrl_mc: expected results queued at issue, popped on done_o.
module tb_alu_ctrl_mc;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned CNT_W  = 7;

  typedef struct packed {
    logic [DATA_W-1:0] res;
    logic              zero;
    logic              err;
    logic [3:0]        ctrl;
  } exp_t;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              valid_i;
  logic [1:0]        ALUOp_i;
  logic [3:0]        funct_i;
  logic [DATA_W-1:0] src1_i;
  logic [DATA_W-1:0] src2_i;
  logic              ready_o;
  logic [3:0]        ALUCtrl_o;
  logic [DATA_W-1:0] result_o;
  logic              zero_o;
  logic              done_o;
  logic              err_o;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  alu_ctrl_mc #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .valid_i  (valid_i),
    .ALUOp_i  (ALUOp_i),
    .funct_i  (funct_i),
    .src1_i   (src1_i),
    .src2_i   (src2_i),
    .ready_o  (ready_o),
    .ALUCtrl_o(ALUCtrl_o),
    .result_o (result_o),
    .zero_o   (zero_o),
    .done_o   (done_o),
    .err_o    (err_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model straight from the opcode table
  function automatic exp_t model(input logic [1:0] op, input logic [3:0] f,
                                 input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    exp_t e;
    e.ctrl = 4'b1111;
    e.res  = '0;
    if (op == 2'b10 && f == 4'b0111) begin e.ctrl = 4'b0000; e.res = a & b; end
    if (op == 2'b10 && f == 4'b0110) begin e.ctrl = 4'b0001; e.res = a | b; end
    if (op == 2'b10 && f == 4'b0000) begin e.ctrl = 4'b0010; e.res = a + b; end
    if (op == 2'b10 && f == 4'b1000) begin e.ctrl = 4'b0110; e.res = a - b; end
    if (op == 2'b10 && f == 4'b0010) begin
      e.ctrl = 4'b0111; e.res = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
    end
    if (op == 2'b00 && (f[2:0] == 3'b011 || f[2:0] == 3'b000)) begin
      e.ctrl = 4'b0010; e.res = a + b;
    end
    if (op == 2'b00 && f[2:0] == 3'b010) begin
      e.ctrl = 4'b0111; e.res = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
    end
    if (op == 2'b01) begin e.ctrl = 4'b0110; e.res = a - b; end
    if (op == 2'b11 && f[2:0] == 3'b000) begin e.ctrl = 4'b1000; e.res = a * b; end
    e.err  = (e.ctrl == 4'b1111);
    e.zero = (e.res == '0);
    return e;
  endfunction

  function automatic exp_t pop_exp();
    exp_t e;
    e = '1;
    if (sb.size() != 0) e = sb.pop_front();
    return e;
  endfunction

  function automatic exp_t observed();
    exp_t o;
    o = {result_o, zero_o, err_o, ALUCtrl_o};
    return o;
  endfunction

  // Present one request for exactly one clock edge; returns at edge+1
  task automatic drive_op(input logic [1:0] op, input logic [3:0] f,
                          input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    valid_i = 1'b1;
    ALUOp_i = op;
    funct_i = f;
    src1_i  = a;
    src2_i  = b;
    sb.push_back(model(op, f, a, b));
    @(posedge clk_i);
    #1;
    valid_i = 1'b0;
  endtask

  task automatic test_reset();
    exp_t o, e;
    rst_i = 1'b1; valid_i = 1'b0; ALUOp_i = '0; funct_i = '0; src1_i = '0; src2_i = '0;
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;
    o = observed();
    e = '{res: '0, zero: 1'b1, err: 1'b0, ctrl: 4'b0000};
    n_vec++;
    if (o !== e || ready_o !== 1'b1 || done_o !== 1'b0) begin
      n_miss++;
      $display("FAIL reset: got %h rdy=%b done=%b, want %h rdy=1 done=0", o, ready_o, done_o, e);
    end
  endtask

  // Issue a single-cycle op and compare the done beat immediately after the accept edge
  task automatic single(input string name, input logic [1:0] op, input logic [3:0] f,
                        input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    exp_t o, e;
    drive_op(op, f, a, b);
    o = observed();
    n_vec++;
    if (done_o !== 1'b1) begin
      n_miss++;
      $display("FAIL %s done: got %b want 1", name, done_o);
    end else begin
      e = pop_exp();
      n_vec++;
      if (o !== e) begin
        n_miss++;
        $display("FAIL %s: got res=%h z=%b e=%b c=%b, want res=%h z=%b e=%b c=%b",
                 name, o.res, o.zero, o.err, o.ctrl, e.res, e.zero, e.err, e.ctrl);
      end
    end
  endtask

  task automatic test_add();
    single("add_5_7", 2'b10, 4'b0000, 64'd5, 64'd7);
    @(posedge clk_i); #1;
    n_vec++;
    if (done_o !== 1'b0) begin
      n_miss++;
      $display("FAIL add_done_pulse: got %b want 0", done_o);
    end
  endtask

  task automatic test_beq_slt();
    single("beq_equal", 2'b01, 4'b0101, 64'h1234, 64'h1234);
    single("slt_m1_1", 2'b10, 4'b0010, '1, 64'd1);
    single("slt_1_m1", 2'b10, 4'b0010, 64'd1, '1);
    single("sub_wrap", 2'b10, 4'b1000, 64'd0, 64'd1);
    single("ld_add", 2'b00, 4'b1011, 64'd10, 64'd20);
    single("slti", 2'b00, 4'b0010, 64'h8000_0000_0000_0000, 64'd0);
    single("add_wrap", 2'b10, 4'b0000, '1, 64'd1);
  endtask

  task automatic test_back_to_back();
    single("b2b_and", 2'b10, 4'b0111, 64'hF0, 64'h3C);
    single("b2b_or", 2'b10, 4'b0110, 64'hF0, 64'h0F);
    for (int i = 0; i < 4; i++)
      single("b2b_rand", 2'b10, 4'b0000, {$urandom, $urandom}, {$urandom, $urandom});
  endtask

  task automatic test_mul();
    exp_t o, e;
    int   lat;
    drive_op(2'b11, 4'b0000, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE);
    for (int i = 0; i < 64; i++) begin
      n_vec++;
      if (ready_o !== 1'b0 || done_o !== 1'b0) begin
        n_miss++;
        $display("FAIL mul_busy[%0d]: got rdy=%b done=%b want 0 0", i, ready_o, done_o);
      end
      valid_i = (i % 8 == 3);
      ALUOp_i = 2'b10; funct_i = 4'b0000;
      src1_i  = {$urandom, $urandom}; src2_i = {$urandom, $urandom};
      @(posedge clk_i); #1;
    end
    valid_i = 1'b0;
    o = observed();
    n_vec++;
    if (done_o !== 1'b1 || ready_o !== 1'b1) begin
      n_miss++;
      $display("FAIL mul_done: got done=%b rdy=%b want 1 1", done_o, ready_o);
    end else begin
      e = pop_exp();
      n_vec++;
      if (o !== e) begin
        n_miss++;
        $display("FAIL mul_3_m2: got res=%h c=%b z=%b, want res=%h c=%b z=%b",
                 o.res, o.ctrl, o.zero, e.res, e.ctrl, e.zero);
      end
    end
    // Random multiplies with a bounded wait for done
    for (int k = 0; k < 3; k++) begin
      drive_op(2'b11, 4'b1000, {$urandom, $urandom}, {$urandom, $urandom});
      lat = 0;
      while (done_o !== 1'b1 && lat < 200) begin
        @(posedge clk_i); #1;
        lat++;
      end
      o = observed();
      e = pop_exp();
      n_vec++;
      if (lat != 64 || o !== e) begin
        n_miss++;
        $display("FAIL mul_rand: got lat=%0d res=%h c=%b, want lat=64 res=%h c=%b",
                 lat, o.res, o.ctrl, e.res, e.ctrl);
      end
    end
  endtask

  task automatic test_illegal();
    single("ill_rtype", 2'b10, 4'b1111, 64'd9, 64'd9);
    single("ill_clear", 2'b10, 4'b0000, 64'd1, 64'd2);
    single("ill_itype", 2'b00, 4'b0101, 64'd3, 64'd4);
    single("ill_mtype", 2'b11, 4'b0001, 64'd3, 64'd4);
    single("ill_then_sub", 2'b01, 4'b0000, 64'd9, 64'd4);
  endtask

  task automatic test_reset_mid_mul();
    exp_t o, e;
    drive_op(2'b11, 4'b0000, 64'd7, 64'd9);
    repeat (10) @(posedge clk_i);
    #1 rst_i = 1'b1;
    @(posedge clk_i);
    #1 rst_i = 1'b0;
    sb.delete();
    o = observed();
    e = '{res: '0, zero: 1'b1, err: 1'b0, ctrl: 4'b0000};
    n_vec++;
    if (o !== e || ready_o !== 1'b1 || done_o !== 1'b0) begin
      n_miss++;
      $display("FAIL mid_mul_reset: got %h rdy=%b done=%b, want %h rdy=1 done=0",
               o, ready_o, done_o, e);
    end
    for (int i = 0; i < 70; i++) begin
      @(posedge clk_i); #1;
      n_vec++;
      if (done_o !== 1'b0) begin
        n_miss++;
        $display("FAIL stale_mul_done[%0d]: got %b want 0", i, done_o);
      end
    end
    single("post_reset_add", 2'b10, 4'b0000, 64'd1, 64'd1);
  endtask

  initial begin
    test_reset();
    test_add();
    test_beq_slt();
    test_back_to_back();
    test_mul();
    test_illegal();
    test_reset_mid_mul();
    repeat (2) @(posedge clk_i);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
